// File: rtl/nios_qsys_pio_gen.sv
// nios_qsys_pio_gen: Avalon-MM parallel I/O port with input synchroniser, edge capture and interrupt
module nios_qsys_pio_gen #(
  parameter int WIDTH       = 8,
  parameter int RESET_VALUE = 0,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_TYPE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);
  localparam logic [31:0] RV = 32'(RESET_VALUE);
  logic [WIDTH-1:0] r_data, r_dir, r_mask, r_edge, r_s1, r_s2, r_s3;
  logic [WIDTH-1:0] w_wd, w_det, w_clr, w_rd;
  logic             w_wr;
  logic             w_unused;
  assign w_wr     = chipselect & ~write_n;
  assign w_wd     = writedata[WIDTH-1:0];
  assign w_unused = &{1'b0, writedata};
  assign w_det    = EDGE_TYPE == 0 ? r_s2 & ~r_s3 : EDGE_TYPE == 1 ? ~r_s2 & r_s3 : r_s2 ^ r_s3;
  assign w_clr    = (w_wr && address == 3'd3) ? w_wd : '0;
  always_ff @(posedge clk)
    if (reset) begin
      r_data <= RV[WIDTH-1:0];
      r_dir  <= '0;
      r_mask <= '0;
      r_edge <= '0;
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
    end else begin
      r_s1   <= in_port;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      // a fresh edge overrides a simultaneous write-1-to-clear
      r_edge <= (r_edge & ~w_clr) | w_det;
      if (w_wr)
        case (address)
          3'd0:    r_data <= w_wd;
          3'd1:    r_dir  <= w_wd;
          3'd2:    r_mask <= w_wd;
          3'd4:    r_data <= r_data | w_wd;
          3'd5:    r_data <= r_data & ~w_wd;
          default: ;
        endcase
    end
  assign w_rd = address == 3'd0 ? (r_data & r_dir) | (r_s2 & ~r_dir) :
                address == 3'd1 ? r_dir :
                address == 3'd2 ? r_mask :
                address == 3'd3 ? r_edge : '0;
  assign readdata = 32'(w_rd);
  assign out_port = r_data;
  assign oe       = r_dir;
  assign irq      = IRQ_TYPE == 1 ? |(r_edge & r_mask) : |(r_s2 & r_mask & ~r_dir);
endmodule

// File: tb/tb_nios_qsys_pio_gen.sv
// tb_nios_qsys_pio_gen: vector table plus scoreboarded sequences for an 8-bit edge-irq PIO and a 5-bit level-irq PIO
module tb_nios_qsys_pio_gen;
  logic        clk = 0;
  logic        reset = 1;
  logic [2:0]  address = 0;
  logic        chipselect = 0;
  logic        write_n = 1;
  logic [31:0] writedata = 0;
  logic [31:0] rd8, rd5;
  logic [7:0]  in8 = 0, out8, oe8;
  logic [4:0]  in5 = 0, out5, oe5;
  logic        irq8, irq5;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  nios_qsys_pio_gen #(.WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .IRQ_TYPE(1)) dut8 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd8), .in_port(in8), .out_port(out8), .oe(oe8), .irq(irq8));

  nios_qsys_pio_gen #(.WIDTH(5), .RESET_VALUE(0), .EDGE_TYPE(1), .IRQ_TYPE(0)) dut5 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd5), .in_port(in5), .out_port(out5), .oe(oe5), .irq(irq5));

  typedef struct { string n; logic [31:0] v; } exp_t;
  exp_t q[$];

  typedef struct {
    logic        cs;
    logic        wr;
    logic [2:0]  a;
    logic [31:0] d;
    logic [7:0]  out;
    logic [31:0] rd;
  } vec_t;
  vec_t vec[13];

  task automatic push(input string n, input logic [31:0] v);
    exp_t e;
    e.n = n;
    e.v = v;
    q.push_back(e);
  endtask

  task automatic got(input logic [31:0] act);
    exp_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
    end else begin
      e = q.pop_front();
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", e.n, act, e.v);
      end
    end
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    push(n, want);
    got(act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    tick();
    chipselect = 0; write_n = 1;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a;
    #1;
  endtask

  initial begin
    vec[0]  = '{1'b1, 1'b1, 3'd1, 32'hFF, 8'hA5, 32'h0};
    vec[1]  = '{1'b1, 1'b1, 3'd0, 32'h0F, 8'h0F, 32'h0};
    vec[2]  = '{1'b1, 1'b1, 3'd4, 32'h30, 8'h3F, 32'h0};
    vec[3]  = '{1'b1, 1'b1, 3'd5, 32'h01, 8'h3E, 32'h0};
    vec[4]  = '{1'b0, 1'b1, 3'd0, 32'h00, 8'h3E, 32'h0};
    vec[5]  = '{1'b1, 1'b0, 3'd0, 32'h00, 8'h3E, 32'h3E};
    vec[6]  = '{1'b1, 1'b0, 3'd4, 32'h00, 8'h3E, 32'h0};
    vec[7]  = '{1'b1, 1'b0, 3'd5, 32'h00, 8'h3E, 32'h0};
    vec[8]  = '{1'b1, 1'b0, 3'd1, 32'h00, 8'h3E, 32'hFF};
    vec[9]  = '{1'b1, 1'b1, 3'd6, 32'hFF, 8'h3E, 32'h0};
    vec[10] = '{1'b1, 1'b0, 3'd6, 32'h00, 8'h3E, 32'h0};
    vec[11] = '{1'b1, 1'b0, 3'd7, 32'h00, 8'h3E, 32'h0};
    vec[12] = '{1'b1, 1'b0, 3'd2, 32'h00, 8'h3E, 32'h0};

    tick(); tick();
    chk("rst_out8", 32'(out8), 32'hA5);
    chk("rst_oe8", 32'(oe8), 32'h0);
    chk("rst_irq8", 32'(irq8), 32'h0);
    chk("rst_out5", 32'(out5), 32'h0);
    wr(3'd0, 32'hFF);
    chk("rst_write_ignored8", 32'(out8), 32'hA5);
    chk("rst_write_ignored5", 32'(out5), 32'h0);
    reset = 0;
    rd(3'd1); chk("rst_dir_rd", rd8, 32'h0);
    rd(3'd2); chk("rst_mask_rd", rd8, 32'h0);
    rd(3'd3); chk("rst_edge_rd", rd8, 32'h0);

    for (int i = 0; i < 13; i++) begin
      chipselect = vec[i].cs; write_n = ~vec[i].wr; address = vec[i].a; writedata = vec[i].d;
      if (!vec[i].wr) push($sformatf("vec%0d_rd", i), vec[i].rd);
      push($sformatf("vec%0d_out", i), 32'(vec[i].out));
      #1;
      if (!vec[i].wr) got(rd8);
      tick();
      chipselect = 0; write_n = 1;
      got(32'(out8));
    end

    wr(3'd2, 32'h01);
    wr(3'd3, 32'hFF);
    in8 = 8'h01;
    tick();
    tick();
    rd(3'd3);
    push("edge_k1", 32'h0); got(rd8);
    push("irq_k1", 32'h0); got(32'(irq8));
    tick();
    push("edge_k2", 32'h1); got(rd8);
    push("irq_k2", 32'h1); got(32'(irq8));
    wr(3'd3, 32'h01);
    rd(3'd3);
    chk("irq_after_w1c", 32'(irq8), 32'h0);
    chk("edge_after_w1c", rd8, 32'h0);

    in8 = 8'h00;
    tick(); tick(); tick();
    in8 = 8'h01;
    tick();
    tick();
    address = 3'd3; writedata = 32'h1; chipselect = 1; write_n = 0;
    tick();
    chipselect = 0; write_n = 1;
    rd(3'd3);
    chk("set_wins_w1c", rd8, 32'h1);
    wr(3'd3, 32'h01);
    rd(3'd3);
    chk("w1c_no_edge", rd8, 32'h0);

    in8 = 8'h00;
    tick(); tick(); tick();
    in8 = 8'h02;
    tick();
    reset = 1;
    tick(); tick();
    reset = 0;
    rd(3'd3);
    chk("rst_mid_edge", rd8, 32'h0);
    chk("rst_mid_oe", 32'(oe8), 32'h0);
    chk("rst_mid_out", 32'(out8), 32'hA5);
    tick(); tick();
    chk("rst_release_s2", rd8, 32'h0);
    tick();
    chk("rst_release_edge", rd8, 32'h2);
    chk("rst_release_irq", 32'(irq8), 32'h0);

    wr(3'd0, 32'hFFFFFFFF);
    wr(3'd1, 32'hFFFFFFFF);
    wr(3'd2, 32'hFFFFFFFF);
    rd(3'd0); chk("w5_data", rd5, 32'h1F);
    rd(3'd1); chk("w5_dir", rd5, 32'h1F);
    rd(3'd2); chk("w5_mask", rd5, 32'h1F);
    rd(3'd6); chk("w5_rsv6", rd5, 32'h0);
    rd(3'd7); chk("w5_rsv7", rd5, 32'h0);
    rd(3'd7); chk("w8_rsv7", rd8, 32'h0);
    wr(3'd6, 32'h0);
    chk("w5_rsv_write", 32'(out5), 32'h1F);

    wr(3'd0, 32'h0A);
    wr(3'd1, 32'h03);
    wr(3'd2, 32'h1C);
    in5 = 5'h10;
    tick();
    chk("lvl_irq_k", 32'(irq5), 32'h0);
    tick();
    chk("lvl_irq_k1", 32'(irq5), 32'h1);
    rd(3'd0); chk("mix_rd0", rd5, 32'h12);
    wr(3'd1, 32'h1F);
    chk("lvl_irq_dir_out", 32'(irq5), 32'h0);
    rd(3'd0); chk("out_rd0", rd5, 32'h0A);

    wr(3'd3, 32'h1F);
    in5 = 5'h00;
    tick();
    tick();
    rd(3'd3); chk("fall_k1", rd5, 32'h0);
    tick();
    chk("fall_k2", rd5, 32'h10);

    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
